// File: rtl/iob_eth_pktbuf_pkg.sv
// Shared types and constants for the Ethernet packet-buffer responder.
package iob_eth_pktbuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int PORT_DMA = 0;
  localparam int PORT_CPU = 1;
  localparam int WAIT_W   = 4;

  // Latched request; the word index lives beside it because its width is per-instance.
  typedef struct packed {
    logic        sel;    // 1 = CPU port granted
    logic        oow;    // DMA address fell outside the window
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/iob_eth_pktbuf_arb.sv
// Two-requester round-robin arbiter; after reset the DMA requester (index 0) has priority.
import iob_eth_pktbuf_pkg::*;

module iob_eth_pktbuf_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic prio_q, prio_d;  // 1 = CPU wins a tie

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
    prio_d = prio_q;
    if (update) prio_d = grant[PORT_DMA];
  end

  always_ff @(posedge clk) begin
    if (!rst) prio_q <= 1'b0;
    else      prio_q <= prio_d;
  end

endmodule

// File: rtl/iob_eth_pktbuf_responder.sv
// Dual-port IOb packet buffer: DMA port (windowed) and CPU port share one memory.
// IOB_ETH_PKTBUF_STATS_EN adds saturating DMA read/write/out-of-window counters.
import iob_eth_pktbuf_pkg::*;

module iob_eth_pktbuf_responder #(
  parameter int                    MEM_ADDR_W = 32,
  parameter int                    DATA_W     = 32,
  parameter int                    BUF_ADDR_W = 10,
  parameter logic [MEM_ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                    WAIT_CYC   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    d_valid,
  input  logic [MEM_ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]       d_wdata,
  input  logic [DATA_W/8-1:0]     d_wstrb,
  output logic [DATA_W-1:0]       d_rdata,
  output logic                    d_ready,
  input  logic                    c_valid,
  input  logic [BUF_ADDR_W+1:0]   c_address,
  input  logic [DATA_W-1:0]       c_wdata,
  input  logic [DATA_W/8-1:0]     c_wstrb,
  output logic [DATA_W-1:0]       c_rdata,
  output logic                    c_ready,
  output logic                    err_o
`ifdef IOB_ETH_PKTBUF_STATS_EN
  ,
  output logic [15:0]             stat_rd_o,
  output logic [15:0]             stat_wr_o,
  output logic [15:0]             stat_oow_o
`endif
);

  // Window bounds are one bit wider than the address so BASE + size never wraps.
  localparam logic [MEM_ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [MEM_ADDR_W:0] WIN_HI = WIN_LO + ({{MEM_ADDR_W{1'b0}}, 1'b1} << (BUF_ADDR_W + 2));

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  req_t                  req_q, req_d;
  logic [BUF_ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     rd_q;
  logic [DATA_W-1:0]     mem [2**BUF_ADDR_W];

  logic [1:0]            arb_req, grant;
  logic                  mem_en, d_oow, resp, rd_ok;
  logic [BUF_ADDR_W-1:0] d_idx, c_idx;

  assign d_oow = ({1'b0, d_address} < WIN_LO) || ({1'b0, d_address} >= WIN_HI);
  assign d_idx = BUF_ADDR_W'((d_address - BASE_ADDR) >> 2);
  assign c_idx = BUF_ADDR_W'(c_address >> 2);

  assign arb_req = (state_q == ST_IDLE) ? {c_valid, d_valid} : 2'b00;

  iob_eth_pktbuf_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (arb_req),
    .update (|grant),
    .grant  (grant)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    idx_d   = idx_q;
    mem_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_W'(WAIT_CYC);
          if (grant[PORT_CPU]) begin
            req_d = '{sel: 1'b1, oow: 1'b0, wstrb: c_wstrb, wdata: c_wdata};
            idx_d = c_idx;
          end else begin
            req_d = '{sel: 1'b0, oow: d_oow, wstrb: d_wstrb, wdata: d_wdata};
            idx_d = d_idx;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          mem_en  = ~req_q.oow;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
    end
  end

  // Single-port memory; a reset landing on the access edge also drops the write.
  always_ff @(posedge clk) begin
    if (mem_en && rst) begin
      for (int b = 0; b < DATA_W/8; b++)
        if (req_q.wstrb[b]) mem[idx_q][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
      rd_q <= mem[idx_q];
    end
  end

  assign resp    = (state_q == ST_RESP);
  assign rd_ok   = (req_q.wstrb == '0) && !req_q.oow;
  assign d_ready = resp && !req_q.sel;
  assign c_ready = resp &&  req_q.sel;
  assign d_rdata = (d_ready && rd_ok) ? rd_q : '0;
  assign c_rdata = (c_ready && rd_ok) ? rd_q : '0;
  assign err_o   = d_ready && req_q.oow;

`ifdef IOB_ETH_PKTBUF_STATS_EN
  logic [15:0] stat_rd_q, stat_rd_d, stat_wr_q, stat_wr_d, stat_oow_q, stat_oow_d;

  always_comb begin
    stat_rd_d  = stat_rd_q;
    stat_wr_d  = stat_wr_q;
    stat_oow_d = stat_oow_q;
    if (d_ready) begin
      if (req_q.oow)                stat_oow_d = sat_inc(stat_oow_q);
      else if (req_q.wstrb == '0)   stat_rd_d  = sat_inc(stat_rd_q);
      else                          stat_wr_d  = sat_inc(stat_wr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      stat_oow_q <= '0;
    end else begin
      stat_rd_q  <= stat_rd_d;
      stat_wr_q  <= stat_wr_d;
      stat_oow_q <= stat_oow_d;
    end
  end

  assign stat_rd_o  = stat_rd_q;
  assign stat_wr_o  = stat_wr_q;
  assign stat_oow_o = stat_oow_q;
`endif

endmodule
